// File: rtl/aes_bus_master.sv
// Command sequencer that runs the full register program of the aes register wrapper
// for one 128-bit block per job, caching the expanded key between jobs.
module aes_bus_master #(
    parameter int POLL_DELAY   = 4,
    parameter int POLL_TIMEOUT = 1000
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_encdec,
    input  logic         cmd_new_key,
    input  logic [127:0] cmd_key,
    input  logic [127:0] cmd_block,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [127:0] res_data,
    output logic         res_error,
    output logic         cs,
    output logic         we,
    output logic [7:0]   address,
    output logic [31:0]  write_data,
    input  logic [31:0]  read_data
);

    localparam logic [7:0] ADDR_CTRL   = 8'h08;
    localparam logic [7:0] ADDR_STATUS = 8'h09;
    localparam logic [7:0] ADDR_CONFIG = 8'h0a;
    localparam logic [7:0] ADDR_KEY    = 8'h10;
    localparam logic [7:0] ADDR_BLOCK  = 8'h20;
    localparam logic [7:0] ADDR_RESULT = 8'h30;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_CFG, S_WR_KEY, S_WR_INIT, S_WAIT_INIT, S_POLL_INIT,
        S_WR_BLK, S_WR_NEXT, S_WAIT_NEXT, S_POLL_NEXT, S_RD_RES, S_OUT
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [15:0]    r_cnt;
    logic [15:0]    w_cnt_next;
    logic           w_timeout;
    logic           w_accept;
    logic           r_cmd_ready;
    logic           r_res_valid;
    logic [127:0]   r_res_data;
    logic           r_res_error;
    logic           r_cs;
    logic           r_we;
    logic [7:0]     r_addr;
    logic [31:0]    r_wdata;
    logic           w_cs;
    logic           w_we;
    logic [7:0]     w_addr;
    logic [31:0]    w_wdata;
    logic [127:0]   r_key;
    logic [127:0]   r_block;
    logic           r_need_init;
    logic           r_key_loaded;

    function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] i);
        case (i)
            2'd0: word_of = v[127:96];
            2'd1: word_of = v[95:64];
            2'd2: word_of = v[63:32];
            default: word_of = v[31:0];
        endcase
    endfunction

    assign w_accept = cmd_valid & r_cmd_ready;

    // r_cnt doubles as word index, wait counter and poll-read counter; it restarts on every state entry.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 16'd1;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (w_accept) w_state_next = S_WR_CFG;
            end
            S_WR_CFG: begin
                w_cnt_next   = '0;
                w_state_next = r_need_init ? S_WR_KEY : S_WR_BLK;
            end
            S_WR_KEY: if (r_cnt == 16'd3) begin w_state_next = S_WR_INIT; w_cnt_next = '0; end
            S_WR_INIT: begin w_state_next = S_WAIT_INIT; w_cnt_next = '0; end
            S_WAIT_INIT: if (r_cnt == 16'(POLL_DELAY - 1)) begin
                w_state_next = S_POLL_INIT; w_cnt_next = '0;
            end
            S_POLL_INIT: begin
                if (read_data[0]) begin
                    w_state_next = S_WR_BLK; w_cnt_next = '0;
                end else if (r_cnt == 16'(POLL_TIMEOUT - 1)) begin
                    w_state_next = S_OUT; w_cnt_next = '0; w_timeout = 1'b1;
                end
            end
            S_WR_BLK: if (r_cnt == 16'd3) begin w_state_next = S_WR_NEXT; w_cnt_next = '0; end
            S_WR_NEXT: begin w_state_next = S_WAIT_NEXT; w_cnt_next = '0; end
            S_WAIT_NEXT: if (r_cnt == 16'(POLL_DELAY - 1)) begin
                w_state_next = S_POLL_NEXT; w_cnt_next = '0;
            end
            S_POLL_NEXT: begin
                if (read_data[1:0] == 2'b11) begin
                    w_state_next = S_RD_RES; w_cnt_next = '0;
                end else if (r_cnt == 16'(POLL_TIMEOUT - 1)) begin
                    w_state_next = S_OUT; w_cnt_next = '0; w_timeout = 1'b1;
                end
            end
            S_RD_RES: if (r_cnt == 16'd3) begin w_state_next = S_OUT; w_cnt_next = '0; end
            S_OUT: begin
                w_cnt_next = '0;
                if (res_ready) w_state_next = S_IDLE;
            end
            default: begin w_state_next = S_IDLE; w_cnt_next = '0; end
        endcase
    end

    // Bus outputs are decoded from the upcoming state so the registered bus lines up with the state.
    always_comb begin
        w_cs    = 1'b0;
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        case (w_state_next)
            S_WR_CFG: begin
                w_cs = 1'b1; w_we = 1'b1; w_addr = ADDR_CONFIG; w_wdata = {31'h0, cmd_encdec};
            end
            S_WR_KEY: begin
                w_cs = 1'b1; w_we = 1'b1;
                w_addr  = ADDR_KEY | {6'h0, w_cnt_next[1:0]};
                w_wdata = word_of(r_key, w_cnt_next[1:0]);
            end
            S_WR_INIT: begin w_cs = 1'b1; w_we = 1'b1; w_addr = ADDR_CTRL; w_wdata = 32'h1; end
            S_WR_BLK: begin
                w_cs = 1'b1; w_we = 1'b1;
                w_addr  = ADDR_BLOCK | {6'h0, w_cnt_next[1:0]};
                w_wdata = word_of(r_block, w_cnt_next[1:0]);
            end
            S_WR_NEXT: begin w_cs = 1'b1; w_we = 1'b1; w_addr = ADDR_CTRL; w_wdata = 32'h2; end
            S_POLL_INIT, S_POLL_NEXT: begin w_cs = 1'b1; w_addr = ADDR_STATUS; end
            S_RD_RES: begin w_cs = 1'b1; w_addr = ADDR_RESULT | {6'h0, w_cnt_next[1:0]}; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_cmd_ready  <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_res_error  <= 1'b0;
            r_cs         <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_key        <= '0;
            r_block      <= '0;
            r_need_init  <= 1'b0;
            r_key_loaded <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values of the others.
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_cmd_ready <= (w_state_next == S_IDLE);
            r_res_valid <= (w_state_next == S_OUT);
            r_cs        <= w_cs;
            r_we        <= w_we;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            if (w_accept) begin
                r_key       <= cmd_key;
                r_block     <= cmd_block;
                r_need_init <= cmd_new_key | ~r_key_loaded;
                r_res_data  <= '0;
                r_res_error <= 1'b0;
            end
            if (r_state == S_POLL_INIT && read_data[0]) r_key_loaded <= 1'b1;
            if (r_state == S_RD_RES) begin
                case (r_cnt[1:0])
                    2'd0: r_res_data[127:96] <= read_data;
                    2'd1: r_res_data[95:64]  <= read_data;
                    2'd2: r_res_data[63:32]  <= read_data;
                    default: r_res_data[31:0] <= read_data;
                endcase
            end
            if (w_timeout) begin
                r_res_error  <= 1'b1;
                r_res_data   <= '0;
                r_key_loaded <= 1'b0;
            end
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign res_error  = r_res_error;
    assign cs         = r_cs;
    assign we         = r_we;
    assign address    = r_addr;
    assign write_data = r_wdata;

endmodule

// File: doc/aes_bus_master.md
# aes_bus_master

Command sequencer that drives the 32-bit register interface (`cs`/`we`/`address`/`write_data`/`read_data`) of the aes register wrapper as its sole bus initiator. It accepts one 128-bit block job per valid/ready handshake, then performs the full register program: config, optional key load with init, block load, next, status polling and result readback. It returns the 128-bit result over a valid/ready result port. The key is cached so that repeated blocks under the same key skip key expansion.

## Interface
- POLL_DELAY, 4, idle cycles after a CTRL write before the first STATUS read (range 1..15).
- POLL_TIMEOUT, 1000, maximum STATUS reads per wait phase before aborting (16-bit).
- clk  in  1  system clock; all logic rises on posedge.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- cmd_valid  in  1  job request.
- cmd_ready  out  1  high only in IDLE.
- cmd_encdec  in  1  1 = encipher, 0 = decipher.
- cmd_new_key  in  1  force key load and init.
- cmd_key  in  128  key; [127:96] is key word 0.
- cmd_block  in  128  block; [127:96] is block word 0.
- res_valid  out  1  result available.
- res_ready  in  1  result accepted.
- res_data  out  128  result; [127:96] is RESULT0.
- res_error  out  1  qualifies res_valid; poll timeout occurred, res_data = 0.
- cs  out  1  bus select.
- we  out  1  bus write.
- address  out  8  bus address.
- write_data  out  32  bus write data.
- read_data  in  32  bus read data, combinational in the same cycle as cs & !we.

## Operation
- Register map: CTRL 0x08 (bit0 init, bit1 next), STATUS 0x09 (bit0 ready, bit1 valid), CONFIG 0x0a (bit0 encdec), KEY0..3 0x10..0x13, BLOCK0..3 0x20..0x23, RESULT0..3 0x30..0x33.
- Handshake `cmd_valid & cmd_ready` latches encdec, key, block and the needs-init flag. The needs-init flag is `cmd_new_key | !key_loaded`.
- FSM states and transitions:
  - IDLE -> WR_CFG
  - WR_CFG -> WR_KEY if needs-init, else WR_BLK
  - WR_KEY (4 words) -> WR_INIT -> WAIT_INIT -> POLL_INIT -> WR_BLK
  - WR_BLK (4 words) -> WR_NEXT -> WAIT_NEXT -> POLL_NEXT -> RD_RES (4 words) -> OUT -> IDLE
- Writes are one cycle each: cs=1, we=1.
  - WR_CFG writes {31'h0, encdec}.
  - WR_KEY/WR_BLK write word i at base+i, i = 0..3 in order.
  - WR_INIT writes 32'h1; WR_NEXT writes 32'h2.
- WAIT states last exactly POLL_DELAY cycles with the bus idle.
- Poll states read STATUS (cs=1, we=0, address=0x09) every cycle, sampling read_data the same cycle.
  - POLL_INIT exits when bit0 = 1, then sets key_loaded = 1.
  - POLL_NEXT exits when bit0 = 1 and bit1 = 1.
- RD_RES reads RESULT0..3 in 4 consecutive cycles. Word i is captured into res_data[127-32i -: 32].
- Timeout: when a poll phase has performed POLL_TIMEOUT reads without success, go to OUT with res_error = 1 and res_data = 0, and clear key_loaded.
- OUT holds res_valid with stable res_data/res_error until res_ready. It returns to IDLE the cycle after acceptance.
- Bus idle value whenever no access: cs=0, we=0, address=8'h00, write_data=0.

## Timing
- Reset values: cmd_ready=0 during reset and 1 in IDLE after release; res_valid=0; res_data=0; res_error=0; bus at idle value; key_loaded=0.
- All outputs are registered.
- Cached-key job, measured from the accept edge to res_valid (P = number of STATUS reads in POLL_NEXT): 1 + 4 + 1 + POLL_DELAY + P + 4 cycles.
- Key-load job adds 4 + 1 + POLL_DELAY + Q cycles (Q = number of STATUS reads in POLL_INIT).
- cmd_valid while busy is ignored (cmd_ready=0); no queuing.
- res_ready held high: res_valid lasts one cycle; the next accept is at earliest 1 cycle later.
- reset_n low mid-job: immediate return to reset values and bus idle. The job is lost and key_loaded is cleared, so the next job reloads the key regardless of cmd_new_key.
- Poll counter resets on entry to each poll state.

## Test plan
- FIPS-197 encrypt: key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff, encdec=1, new_key=1 -> res_data 69c4e0d86a7b0430d8cdb78070b4c55a, res_error=0, bus trace CONFIG, KEY0..3, CTRL=1, STATUS polls, BLOCK0..3, CTRL=2, polls, RESULT0..3.
- Cached-key decrypt: same key, new_key=0, block 69c4e0d86a7b0430d8cdb78070b4c55a, encdec=0 -> res_data 00112233445566778899aabbccddeeff; no writes to 0x10..0x13 and no CTRL=1 observed.
- Backpressure: res_ready low for 10 cycles -> res_valid and res_data stable for all 10 cycles, cmd_ready=0 throughout, IDLE the cycle after acceptance.
- Timeout: bus model returns STATUS=0 forever, POLL_TIMEOUT=8 -> exactly 8 STATUS reads, then res_valid=1, res_error=1, res_data=0; next job with new_key=0 still performs key load.
- Reset mid-job: assert reset_n low during WR_BLK -> cs=0 asynchronously, res_valid=0; next job reloads the key.
- Latency: instant-ready bus model with P=1, POLL_DELAY=4 -> res_valid exactly 15 cycles after the cached-key accept edge.
